// File: rtl/word_arbiter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : word_arbiter_ctrl_if
//  Description : Bundles the two requester channels and the word-array side
//                of word_arbiter_ctrl.
//                master : requesters plus the array read-data return
//                         (req*, we*, addr*, wdata*, out_bus in;
//                         gnt*, done*, rdata, word_sel, op, in_bus, err out).
//                slave  : the arbiter controller itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface word_arbiter_ctrl_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    // Requester side
    logic                   req0;
    logic                   req1;
    logic                   we0;
    logic                   we1;
    logic [ADDR_W-1:0]      addr0;
    logic [ADDR_W-1:0]      addr1;
    logic [DATA_W-1:0]      wdata0;
    logic [DATA_W-1:0]      wdata1;
    logic                   gnt0;
    logic                   gnt1;
    logic                   done0;
    logic                   done1;
    logic [DATA_W-1:0]      rdata;
    // Word-array side
    logic [(2**ADDR_W)-1:0] word_sel;
    logic                   op;
    logic [DATA_W-1:0]      in_bus;
    logic [DATA_W-1:0]      out_bus;
    // Status
    logic                   err;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, out_bus,
        input  gnt0, gnt1, done0, done1, rdata, word_sel, op, in_bus, err
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, out_bus,
        output gnt0, gnt1, done0, done1, rdata, word_sel, op, in_bus, err
    );
endinterface
`default_nettype wire

// File: rtl/word_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : word_arbiter_ctrl
//  Description : Two-requester round-robin arbiter in front of a word array.
//                Each transaction runs IDLE -> SETUP -> ACCESS -> DONE; the
//                winner sees a one-cycle gnt in SETUP and a one-cycle done in
//                DONE. Reads capture out_bus into rdata on the ACCESS->DONE
//                edge.
//                Optional feature: define WORD_ARBITER_WRITE_VERIFY_EN to add
//                a VERIFY cycle after every write that reads the word back
//                and sets the sticky err flag on mismatch.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - word_arbiter_ctrl_if.slave (requests, grants, dones,
//                       rdata, word_sel, op, in_bus, out_bus, err)
//  Revision    : 1.0 - initial release
// ============================================================================
module word_arbiter_ctrl #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    word_arbiter_ctrl_if.slave  bus
);

    localparam int                 c_WORDS   = 2 ** ADDR_W;
    localparam logic [c_WORDS-1:0] c_SEL_ONE = {{(c_WORDS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        DONE   = 3'd3
`ifdef WORD_ARBITER_WRITE_VERIFY_EN
        ,
        VERIFY = 3'd4
`endif
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Latched transaction; inputs are never re-sampled after IDLE.
    logic                r_owner;     // 0: requester 0, 1: requester 1
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_last;      // requester served most recently
    logic [DATA_W-1:0]   r_rdata;

    logic                w_any_req;
    logic                w_pick;
    logic                w_drive;     // SETUP or ACCESS: array is being driven
    logic                w_sel_on;    // word_sel held (also through VERIFY)

    // ------------------------------------------------------------------
    // Round-robin pick: a lone requester wins; on a tie the one not served
    // last wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_any_req = bus.req0 | bus.req1;
        w_pick    = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_pick = ~r_last;
        end else if (bus.req1) begin
            w_pick = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
`ifdef WORD_ARBITER_WRITE_VERIFY_EN
                w_next_state = r_we ? VERIFY : DONE;
`else
                w_next_state = DONE;
`endif
            end
`ifdef WORD_ARBITER_WRITE_VERIFY_EN
            VERIFY: begin
                w_next_state = DONE;
            end
`endif
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the state register only, so they are glitch
    // free with respect to the request inputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_drive  = (r_state == SETUP) || (r_state == ACCESS);
        w_sel_on = w_drive;
`ifdef WORD_ARBITER_WRITE_VERIFY_EN
        // Keep the word selected while the array returns the written data.
        w_sel_on = w_drive || (r_state == VERIFY);
`endif
    end

    assign bus.gnt0     = (r_state == SETUP) && !r_owner;
    assign bus.gnt1     = (r_state == SETUP) &&  r_owner;
    assign bus.done0    = (r_state == DONE)  && !r_owner;
    assign bus.done1    = (r_state == DONE)  &&  r_owner;
    assign bus.word_sel = w_sel_on ? (c_SEL_ONE << r_addr) : '0;
    assign bus.op       = w_drive & r_we;
    assign bus.in_bus   = (w_drive && r_we) ? r_wdata : '0;
    assign bus.rdata    = r_rdata;

    // ------------------------------------------------------------------
    // State register and transaction latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_last  <= 1'b1;    // requester 0 wins the first tie
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && w_any_req) begin
                r_owner <= w_pick;
                r_we    <= w_pick ? bus.we1    : bus.we0;
                r_addr  <= w_pick ? bus.addr1  : bus.addr0;
                r_wdata <= w_pick ? bus.wdata1 : bus.wdata0;
            end
            if ((r_state == ACCESS) && !r_we) begin
                r_rdata <= bus.out_bus;
            end
            // Pointer moves only on completion, so an aborted transaction
            // does not count as served.
            if (r_state == DONE) begin
                r_last <= r_owner;
            end
        end
    end

`ifdef WORD_ARBITER_WRITE_VERIFY_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == VERIFY) && (bus.out_bus != r_wdata)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_word_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_arbiter_ctrl
//  Description : Self-checking bench for word_arbiter_ctrl. A 4-word array
//                model answers word_sel/op; a transaction-level model tracks
//                the expected outputs from the age of the current
//                transaction; directed sequences pin specific values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_word_arbiter_ctrl;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;
`ifdef WORD_ARBITER_WRITE_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    word_arbiter_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    word_arbiter_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Word array: writes land while op is high, reads return the selected
    // word. 'corrupt' flips bit 0 of readback to emulate a bad cell.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [4];
    logic [DATA_W-1:0] arr_out;
    logic              corrupt = 1'b0;

    always_comb begin
        arr_out = '0;
        for (int k = 0; k < 4; k++) begin
            if (bus.word_sel[k]) arr_out = mem[k];
        end
        if (corrupt && !bus.op && (bus.word_sel != 4'b0000)) arr_out = arr_out ^ 8'h01;
    end
    assign bus.out_bus = arr_out;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus.op && bus.word_sel[k]) mem[k] <= bus.in_bus;
        end
    end

    // ------------------------------------------------------------------
    // Behavioural model: m_age counts cycles since the grant edge
    // (0 = no transaction). Grant at age 1, array driven at ages 1..2,
    // done at age 3, or age 4 for a verified write.
    // ------------------------------------------------------------------
    int                m_age   = 0;
    bit                m_owner = 1'b0;
    bit                m_we    = 1'b0;
    bit                m_last  = 1'b1;
    bit                m_err   = 1'b0;
    logic [1:0]        m_addr  = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [DATA_W-1:0] m_rdata = '0;

    function automatic int done_age();
        return (VERIFY_EN && m_we) ? 4 : 3;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_age   = 0;
            m_last  = 1'b1;
            m_err   = 1'b0;
            m_rdata = '0;
        end else if (m_age == 0) begin
            if (bus.req0 || bus.req1) begin
                m_owner = (bus.req0 && bus.req1) ? !m_last : bus.req1;
                m_we    = m_owner ? bus.we1    : bus.we0;
                m_addr  = m_owner ? bus.addr1  : bus.addr0;
                m_wdata = m_owner ? bus.wdata1 : bus.wdata0;
                m_age   = 1;
            end
        end else begin
            if (m_age == 2 && !m_we) m_rdata = mem[m_addr];
            // Readback differs from the written word exactly when the array
            // is corrupting reads.
            if (m_age == 3 && m_we && VERIFY_EN && corrupt) m_err = 1'b1;
            if (m_age == done_age()) begin
                m_last = m_owner;
                m_age  = 0;
            end else begin
                m_age++;
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin : compare
        logic [3:0] exp_sel;
        bit         sel_on;
        bit         drive;
        if (chk_en) begin
            drive   = (m_age == 1) || (m_age == 2);
            sel_on  = drive || (m_age == 3 && m_we && VERIFY_EN);
            exp_sel = sel_on ? (4'b0001 << m_addr) : 4'b0000;
            check("model_gnt0",     bus.gnt0,     (m_age == 1) && !m_owner);
            check("model_gnt1",     bus.gnt1,     (m_age == 1) &&  m_owner);
            check("model_done0",    bus.done0,    (m_age != 0) && (m_age == done_age()) && !m_owner);
            check("model_done1",    bus.done1,    (m_age != 0) && (m_age == done_age()) &&  m_owner);
            check("model_word_sel", bus.word_sel, exp_sel);
            check("model_op",       bus.op,       drive && m_we);
            check("model_in_bus",   bus.in_bus,   (drive && m_we) ? m_wdata : 8'h00);
            check("model_rdata",    bus.rdata,    m_rdata);
            check("model_err",      bus.err,      m_err);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.we0  = 1'b0; bus.we1  = 1'b0;
        bus.addr0 = '0;  bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
    endtask

    task automatic single_write0(input logic [1:0] a, input logic [7:0] d);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = a; bus.wdata0 = d;
        tick();
        bus.req0 = 1'b0;
        repeat (5) tick();
    endtask

    int ord [4];
    int gcyc [4];
    int ng;

    initial begin
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'hA5; mem[3] = 8'h5A;
        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        chk_en = 1'b1;

        // Reset values
        check("rst_gnt",      {bus.gnt0, bus.gnt1},   2'b00);
        check("rst_done",     {bus.done0, bus.done1}, 2'b00);
        check("rst_word_sel", bus.word_sel, 4'b0000);
        check("rst_op",       bus.op,       1'b0);
        check("rst_in_bus",   bus.in_bus,   8'h00);
        check("rst_rdata",    bus.rdata,    8'h00);
        check("rst_err",      bus.err,      1'b0);
        rst = 1'b0;
        tick();

        // Single read of word 2
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd2;
        tick();                                         // N+1
        check("rd_gnt0",   bus.gnt0,     1'b1);
        check("rd_sel_n1", bus.word_sel, 4'b0100);
        check("rd_op_n1",  bus.op,       1'b0);
        bus.req0 = 1'b0;
        tick();                                         // N+2
        check("rd_sel_n2", bus.word_sel, 4'b0100);
        tick();                                         // N+3
        check("rd_done0",  bus.done0,    1'b1);
        check("rd_rdata",  bus.rdata,    8'hA5);
        tick();                                         // N+4
        check("rd_done0_off",  bus.done0, 1'b0);
        check("rd_rdata_held", bus.rdata, 8'hA5);

        // Single write of 0x3C to word 3 from requester 1
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 2'd3; bus.wdata1 = 8'h3C;
        tick();                                         // N+1
        check("wr_gnt1",   bus.gnt1,     1'b1);
        check("wr_sel",    bus.word_sel, 4'b1000);
        check("wr_op",     bus.op,       1'b1);
        check("wr_in_bus", bus.in_bus,   8'h3C);
        bus.req1 = 1'b0;
        tick();                                         // N+2
        check("wr_op_n2",  bus.op,       1'b1);
        tick();                                         // N+3
        check("wr_done1_n3", bus.done1,    !VERIFY_EN);
        check("wr_sel_n3",   bus.word_sel, VERIFY_EN ? 4'b1000 : 4'b0000);
        check("wr_op_n3",    bus.op,       1'b0);
        tick();                                         // N+4
        check("wr_done1_n4", bus.done1,    VERIFY_EN);
        tick();
        idle_inputs();

        // Contention from reset: both requesters held high
        rst = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 2'd0; bus.addr1 = 2'd3;
        tick();
        rst = 1'b0;
        ng = 0;
        for (int i = 0; i < 4; i++) begin ord[i] = -1; gcyc[i] = -1; end
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            check("cont_no_overlap", bus.gnt0 & bus.gnt1, 1'b0);
            if (bus.gnt0 || bus.gnt1) begin
                ord[ng]  = bus.gnt1 ? 1 : 0;
                gcyc[ng] = c;
                ng++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("cont_grants", ng, 4);
        for (int i = 0; i < 4; i++) check("cont_order", ord[i], i % 2);
        for (int i = 0; i < 3; i++) check("cont_spacing", gcyc[i+1] - gcyc[i], 4);
        repeat (4) tick();

        // Reset in ACCESS: requester 0 served alone, so the tie goes to 1
        bus.req0 = 1'b1; bus.addr0 = 2'd1;
        tick();
        bus.req0 = 1'b0;
        repeat (3) tick();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        tick();                                         // SETUP
        check("rr_tie_to_1", bus.gnt1, 1'b1);
        tick();                                         // ACCESS
        rst = 1'b1;
        tick();
        check("abort_sel",  bus.word_sel, 4'b0000);
        check("abort_op",   bus.op,       1'b0);
        check("abort_done", {bus.done0, bus.done1}, 2'b00);
        rst = 1'b0;
        tick();
        check("abort_tie_to_0", bus.gnt0, 1'b1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (4) tick();

        // Write verify: bad readback, then a matching write, then reset
        corrupt = 1'b1;
        single_write0(2'd1, 8'hFF);
        corrupt = 1'b0;
        check("verify_bad_err", bus.err, VERIFY_EN);
        single_write0(2'd2, 8'h77);
        check("verify_sticky_err", bus.err, VERIFY_EN);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("verify_err_cleared", bus.err, 1'b0);
        single_write0(2'd0, 8'h42);
        check("verify_good_err", bus.err, 1'b0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/word_arbiter_ctrl.md
WORD_ARBITER_CTRL -- requirements
Module: word_arbiter_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, meaning the word address width; the array holds 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports req0/req1, input, 1 bit each: access request from requester 0/1.
REQ-006 SHALL have ports we0/we1, input, 1 bit each: 1 selects write, 0 selects read.
REQ-007 SHALL have ports addr0/addr1, input, ADDR_W each: target word.
REQ-008 SHALL have ports wdata0/wdata1, input, DATA_W each: write data.
REQ-009 SHALL have ports gnt0/gnt1, output, 1 bit each: one-cycle grant pulse.
REQ-010 SHALL have ports done0/done1, output, 1 bit each: one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, DATA_W: read result, valid while done is high and held until the next read completes.
REQ-012 SHALL have port word_sel, output, 2**ADDR_W: one-hot word select to the array.
REQ-013 SHALL have port op, output, 1 bit: array read/write control, 1 means write.
REQ-014 SHALL have port in_bus, output, DATA_W: write data to the array.
REQ-015 SHALL have port out_bus, input, DATA_W: read data from the array.
REQ-016 SHALL have port err, output, 1 bit: sticky write-verify mismatch flag.

Function
REQ-017 SHALL implement the FSM states IDLE, SETUP, ACCESS and DONE (plus VERIFY, see Configuration).
REQ-018 IDLE: if any req is high, SHALL pick a winner, latch its we/addr/wdata, and go to SETUP; otherwise SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: a lone requester always wins; when both request, the requester not served last wins.
REQ-020 SHALL assert the winner's gnt for exactly the one cycle spent in SETUP.
REQ-021 SETUP and ACCESS: word_sel SHALL be one-hot of the latched addr, op SHALL equal the latched we, and in_bus SHALL equal the latched wdata (0 on a read).
REQ-022 After ACCESS the FSM SHALL go to DONE; on a read, rdata SHALL be loaded from out_bus at the ACCESS→DONE edge.
REQ-023 DONE: SHALL pulse the winner's done for one cycle, drive word_sel to 0 and op to 0, update the last-served pointer, and return to IDLE.
REQ-024 Latency SHALL be: req sampled in IDLE at edge N; gnt high in cycle N+1; done high in cycle N+3; the next grant is possible at cycle N+5 at the earliest.
REQ-025 Outside SETUP/ACCESS/VERIFY, word_sel SHALL be all-zero and op SHALL be 0.
REQ-026 A req that arrives while the FSM is not in IDLE SHALL wait, and SHALL be evaluated at the next IDLE.
REQ-027 If req drops after the grant, the transaction SHALL still complete; inputs SHALL NOT be re-sampled mid-transaction.
REQ-028 When both req are held continuously, grants SHALL strictly alternate 0,1,0,1.

Reset
REQ-029 While rst is high at an edge, the FSM SHALL return to IDLE from any state, including mid-transaction; no done is issued for the aborted transaction.
REQ-030 Reset values SHALL be: gnt0/gnt1/done0/done1 = 0, word_sel = 0, op = 0, in_bus = 0, rdata = 0, err = 0.
REQ-031 Reset SHALL set the last-served pointer to requester 1, so requester 0 wins the first tie.

Configuration
REQ-032 Macro WORD_ARBITER_WRITE_VERIFY_EN: when defined, a write SHALL go ACCESS→VERIFY→DONE.
REQ-033 In VERIFY, op SHALL be 0 with word_sel held; if out_bus differs from the latched wdata, err SHALL be set to 1, cleared only by rst.
REQ-034 With the macro defined, write done SHALL occur at N+4; reads SHALL be unaffected.
REQ-035 When the macro is undefined, VERIFY SHALL NOT exist and err SHALL be tied to 0.

Verification
REQ-036 Single read: rst, then req0=1, we0=0, addr0=2, array word2=0xA5 -> gnt0 at N+1, word_sel=4'b0100 with op=0 during N+1..N+2, done0 and rdata=0xA5 at N+3.
REQ-037 Single write: req1=1, we1=1, addr1=3, wdata1=0x3C -> word_sel=4'b1000, op=1, in_bus=0x3C during SETUP/ACCESS; done1 at N+3 (N+4 with the macro defined).
REQ-038 Contention: req0 and req1 held high from reset -> grant order 0,1,0,1 with no overlap between transactions.
REQ-039 Reset mid-operation: assert rst in ACCESS -> next cycle word_sel=0, op=0, no done, FSM in IDLE; the next tie goes to requester 0.
REQ-040 Write verify (macro defined): write 0xFF while the model returns 0xFE in VERIFY -> err=1 and held until rst; a matching write leaves err=0.
